// File: rtl/tmds_pkg.sv
// Shared TMDS types, fixed code words and encoding helpers.
package tmds_pkg;

    localparam int unsigned SYM_W = 10;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [2:0] {
        MODE_CTRL        = 3'd0,
        MODE_VIDEO       = 3'd1,
        MODE_VIDEO_GB    = 3'd2,
        MODE_DATA_ISLAND = 3'd3,
        MODE_DATA_GB     = 3'd4
    } mode_e;

    localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

    localparam logic [SYM_W-1:0] GB_EVEN = 10'b1011001100;
    localparam logic [SYM_W-1:0] GB_ODD  = 10'b0100110011;

    // Control period symbol for {c1,c0}.
    function automatic logic [SYM_W-1:0] ctrl_code(input logic [1:0] c);
        logic [SYM_W-1:0] sym;
        case (c)
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
        endcase
        return sym;
    endfunction

    // TERC4 symbol for a data-island nibble.
    function automatic logic [SYM_W-1:0] terc4(input logic [3:0] nib);
        logic [SYM_W-1:0] sym;
        case (nib)
            4'h0:    sym = 10'b1010011100;
            4'h1:    sym = 10'b1001100011;
            4'h2:    sym = 10'b1011100100;
            4'h3:    sym = 10'b1011100010;
            4'h4:    sym = 10'b0101110001;
            4'h5:    sym = 10'b0100011110;
            4'h6:    sym = 10'b0110001110;
            4'h7:    sym = 10'b0100111100;
            4'h8:    sym = 10'b1011001100;
            4'h9:    sym = 10'b0100111001;
            4'hA:    sym = 10'b0110011100;
            4'hB:    sym = 10'b1011000110;
            4'hC:    sym = 10'b1010001110;
            4'hD:    sym = 10'b1001110001;
            4'hE:    sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    // Population count of one byte (0..8).
    function automatic logic [3:0] ones8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(d[i]);
        end
        return n;
    endfunction

    // Transition-minimising first stage; bit 8 is set when XOR was used.
    function automatic logic [8:0] video_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = ones8(d);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        qm[8] = ~use_xnor;
        return qm;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS lane: optional q_m pipeline stage, disparity tracking and period select.
module tmds_channel
    import tmds_pkg::*;
#(
    parameter int unsigned PIPE   = 1,
    parameter int unsigned CH_IDX = 0
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [2:0]       mode,
    input  logic [7:0]       vd,
    input  logic [1:0]       cd,
    input  logic [3:0]       aux,
    output logic [SYM_W-1:0] tmds
);

    localparam logic [SYM_W-1:0] VIDEO_GB_SYM = ((CH_IDX % 2) == 0) ? GB_EVEN : GB_ODD;

    if ((PIPE != 1) && (PIPE != 2)) begin : g_bad_pipe
        $error("tmds_channel: PIPE must be 1 or 2");
    end

    logic [8:0] qm_c;
    logic [3:0] n1_c;

    assign qm_c = video_qm(vd);
    assign n1_c = ones8(qm_c[7:0]);

    // Fields seen by the output stage, either straight from the ports or one stage late.
    logic [2:0] s_mode;
    logic [1:0] s_cd;
    logic [3:0] s_aux;
    logic [8:0] s_qm;
    logic [3:0] s_n1;

    if (PIPE == 2) begin : g_pipe2
        logic [2:0] mode_q;
        logic [1:0] cd_q;
        logic [3:0] aux_q;
        logic [8:0] qm_q;
        logic [3:0] n1_q;

        // Stage 1: register q_m, its ones count and the aligned side-band fields.
        always_ff @(posedge clk_pix or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= 3'(MODE_CTRL);
                cd_q   <= '0;
                aux_q  <= '0;
                qm_q   <= '0;
                n1_q   <= '0;
            end else if (ce) begin
                mode_q <= mode;
                cd_q   <= cd;
                aux_q  <= aux;
                qm_q   <= qm_c;
                n1_q   <= n1_c;
            end
        end

        assign s_mode = mode_q;
        assign s_cd   = cd_q;
        assign s_aux  = aux_q;
        assign s_qm   = qm_q;
        assign s_n1   = n1_q;
    end else begin : g_pipe1
        assign s_mode = mode;
        assign s_cd   = cd;
        assign s_aux  = aux;
        assign s_qm   = qm_c;
        assign s_n1   = n1_c;
    end

    logic [SYM_W-1:0]        tmds_q, tmds_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [CNT_W:0]   cnt_ext;
    logic signed [CNT_W:0]   diff;
    logic signed [CNT_W:0]   cnt_sum;
    logic                    cnt_pos;
    logic                    cnt_neg;

    // Output stage: disparity decision, period select and next running disparity.
    always_comb begin
        tmds_d  = ctrl_code(s_cd);
        cnt_d   = '0;
        cnt_sum = '0;
        cnt_ext = {cnt_q[CNT_W-1], cnt_q};
        diff    = $signed({1'b0, s_n1, 1'b0}) - 6'sd8;
        cnt_neg = cnt_q[CNT_W-1];
        cnt_pos = !cnt_q[CNT_W-1] && (cnt_q != '0);

        case (s_mode)
            MODE_VIDEO: begin
                if ((cnt_q == '0) || (s_n1 == 4'd4)) begin
                    tmds_d  = {~s_qm[8], s_qm[8], s_qm[8] ? s_qm[7:0] : ~s_qm[7:0]};
                    cnt_sum = cnt_ext + (s_qm[8] ? diff : -diff);
                end else if ((cnt_pos && (s_n1 > 4'd4)) || (cnt_neg && (s_n1 < 4'd4))) begin
                    tmds_d  = {1'b1, s_qm[8], ~s_qm[7:0]};
                    cnt_sum = cnt_ext + (s_qm[8] ? 6'sd2 : 6'sd0) - diff;
                end else begin
                    tmds_d  = {1'b0, s_qm[8], s_qm[7:0]};
                    cnt_sum = cnt_ext - (s_qm[8] ? 6'sd0 : 6'sd2) + diff;
                end
                cnt_d = cnt_sum[CNT_W-1:0];
            end
            MODE_VIDEO_GB:    tmds_d = VIDEO_GB_SYM;
            MODE_DATA_ISLAND: tmds_d = terc4(s_aux);
            MODE_DATA_GB:     tmds_d = (CH_IDX == 0) ? terc4(s_aux) : GB_ODD;
            default:          tmds_d = ctrl_code(s_cd);
        endcase
    end

    // Output symbol and running disparity; both hold while ce is low.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            tmds_q <= CTRL_00;
            cnt_q  <= '0;
        end else if (ce) begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// Multi-channel HDMI TMDS encoder: one tmds_channel per lane sharing mode, ce and reset.
module tmds_encoder_multi
    import tmds_pkg::*;
#(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned PIPE   = 1
) (
    input  logic                    clk_pix,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic [2:0]              mode,
    input  logic [8*NUM_CH-1:0]     vd,
    input  logic [2*NUM_CH-1:0]     cd,
    input  logic [4*NUM_CH-1:0]     aux,
    output logic [SYM_W*NUM_CH-1:0] tmds
);

    if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
        $error("tmds_encoder_multi: NUM_CH must be 1..8");
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_channel #(
            .PIPE   (PIPE),
            .CH_IDX (k)
        ) u_ch (
            .clk_pix (clk_pix),
            .rst_n   (rst_n),
            .ce      (ce),
            .mode    (mode),
            .vd      (vd[8*k +: 8]),
            .cd      (cd[2*k +: 2]),
            .aux     (aux[4*k +: 4]),
            .tmds    (tmds[SYM_W*k +: SYM_W])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: PIPE=1 and PIPE=2 instances on shared stimulus.
module tb_tmds_encoder_multi;

    localparam int NCH = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ce;
    logic [2:0]          mode;
    logic [8*NCH-1:0]    vd;
    logic [2*NCH-1:0]    cd;
    logic [4*NCH-1:0]    aux;
    logic [10*NCH-1:0]   tmds1;
    logic [10*NCH-1:0]   tmds2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: running disparity and expected outputs per lane.
    int         m_cnt [NCH];
    logic [9:0] exp1  [NCH];
    logic [9:0] exp2  [NCH];

    logic [9:0] terc_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };
    logic [9:0] ctrl_tab [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    always #5 clk = ~clk;

    tmds_encoder_multi #(.NUM_CH(NCH), .PIPE(1)) dut1 (
        .clk_pix (clk), .rst_n (rst_n), .ce (ce), .mode (mode),
        .vd (vd), .cd (cd), .aux (aux), .tmds (tmds1)
    );

    tmds_encoder_multi #(.NUM_CH(NCH), .PIPE(2)) dut2 (
        .clk_pix (clk), .rst_n (rst_n), .ce (ce), .mode (mode),
        .vd (vd), .cd (cd), .aux (aux), .tmds (tmds2)
    );

    // DVI 1.0 video encoding with an unbounded integer disparity.
    function automatic logic [9:0] m_video(input int ch, input logic [7:0] d);
        int         ones, n1, n0;
        bit         inv;
        logic [8:0] qm;
        logic [9:0] o;
        ones  = $countones(d);
        inv   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~inv;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (m_cnt[ch] == 0 || n1 == n0) begin
            o = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
            m_cnt[ch] += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((m_cnt[ch] > 0 && n1 > n0) || (m_cnt[ch] < 0 && n0 > n1)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            m_cnt[ch] += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            m_cnt[ch] += (qm[8] ? 0 : -2) + n1 - n0;
        end
        return o;
    endfunction

    function automatic logic [9:0] m_encode(input int ch);
        logic [3:0] a;
        logic [1:0] c;
        a = aux[4*ch +: 4];
        c = cd[2*ch +: 2];
        if (mode == 3'd1) return m_video(ch, vd[8*ch +: 8]);
        m_cnt[ch] = 0;
        case (mode)
            3'd2:    return (ch % 2 == 0) ? 10'h2CC : 10'h133;
            3'd3:    return terc_tab[a];
            3'd4:    return (ch == 0) ? terc_tab[a] : 10'h133;
            default: return ctrl_tab[c];
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            exp1[c]  = 10'h354;
            exp2[c]  = 10'h354;
        end
    endtask

    // One clock; the model advances on ce-qualified edges; returns 1 time unit later.
    task automatic step();
        @(posedge clk);
        if (rst_n && ce) begin
            for (int c = 0; c < NCH; c++) begin
                exp2[c] = exp1[c];
                exp1[c] = m_encode(c);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1; mode = 3'd0; vd = '0; cd = '0; aux = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (tmds1[10*c +: 10] !== 10'h354) begin
                n_bad++; $display("FAIL reset_p1 ch%0d got %h want 354", c, tmds1[10*c +: 10]);
            end
            n_cmp++;
            if (tmds2[10*c +: 10] !== 10'h354) begin
                n_bad++; $display("FAIL reset_p2 ch%0d got %h want 354", c, tmds2[10*c +: 10]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        cd    = 6'b000001;
        for (int s = 0; s < 2; s++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== ((c == 0) ? 10'h0AB : 10'h354)) begin
                    n_bad++; $display("FAIL ctrl_p1 s%0d ch%0d got %h", s, c, tmds1[10*c +: 10]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== ((c == 0 && s == 1) ? 10'h0AB : 10'h354)) begin
                    n_bad++; $display("FAIL ctrl_p2 s%0d ch%0d got %h", s, c, tmds2[10*c +: 10]);
                end
            end
        end
    endtask

    task automatic test_video_zero();
        logic [9:0] want [3];
        want[0] = 10'h100; want[1] = 10'h3FF; want[2] = 10'h100;
        mode = 3'd1; vd = '0;
        for (int s = 0; s < 3; s++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== want[s]) begin
                    n_bad++; $display("FAIL vid0_p1 s%0d ch%0d got %h want %h", s, c, tmds1[10*c +: 10], want[s]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== exp2[c] || (s > 0 && exp2[c] !== want[s-1])) begin
                    n_bad++; $display("FAIL vid0_p2 s%0d ch%0d got %h want %h", s, c, tmds2[10*c +: 10], exp2[c]);
                end
            end
        end
    endtask

    task automatic test_ce_hold();
        step();
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (tmds1[10*c +: 10] !== 10'h3FF) begin
                n_bad++; $display("FAIL prehold_p1 ch%0d got %h want 3ff", c, tmds1[10*c +: 10]);
            end
        end
        ce = 1'b0;
        for (int s = 0; s < 4; s++) begin
            vd   = 24'($urandom);
            mode = 3'($urandom_range(0, 7));
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== exp1[c]) begin
                    n_bad++; $display("FAIL hold_p1 s%0d ch%0d got %h want %h", s, c, tmds1[10*c +: 10], exp1[c]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== exp2[c]) begin
                    n_bad++; $display("FAIL hold_p2 s%0d ch%0d got %h want %h", s, c, tmds2[10*c +: 10], exp2[c]);
                end
            end
        end
        ce = 1'b1; mode = 3'd1; vd = '0;
        for (int s = 0; s < 3; s++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== exp1[c] || (s == 0 && exp1[c] !== 10'h100)) begin
                    n_bad++; $display("FAIL resume_p1 s%0d ch%0d got %h want %h", s, c, tmds1[10*c +: 10], exp1[c]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== exp2[c]) begin
                    n_bad++; $display("FAIL resume_p2 s%0d ch%0d got %h want %h", s, c, tmds2[10*c +: 10], exp2[c]);
                end
            end
        end
    endtask

    task automatic test_guard_bands();
        mode = 3'd2;
        step();
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (tmds1[10*c +: 10] !== ((c % 2 == 0) ? 10'h2CC : 10'h133)) begin
                n_bad++; $display("FAIL vgb_p1 ch%0d got %h", c, tmds1[10*c +: 10]);
            end
        end
        mode = 3'd4; aux = '0;
        step();
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (tmds1[10*c +: 10] !== ((c == 0) ? 10'h29C : 10'h133)) begin
                n_bad++; $display("FAIL dgb_p1 ch%0d got %h", c, tmds1[10*c +: 10]);
            end
            n_cmp++;
            if (tmds2[10*c +: 10] !== ((c % 2 == 0) ? 10'h2CC : 10'h133)) begin
                n_bad++; $display("FAIL dgb_p2 ch%0d got %h", c, tmds2[10*c +: 10]);
            end
        end
    endtask

    task automatic test_data_island();
        logic [3:0] a;
        mode = 3'd3;
        for (int i = 0; i < 16; i++) begin
            a   = 4'(i);
            aux = {a, a, a};
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== terc_tab[i]) begin
                    n_bad++; $display("FAIL terc4_p1 nib%0d ch%0d got %h want %h", i, c, tmds1[10*c +: 10], terc_tab[i]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== exp2[c]) begin
                    n_bad++; $display("FAIL terc4_p2 nib%0d ch%0d got %h want %h", i, c, tmds2[10*c +: 10], exp2[c]);
                end
            end
        end
        mode = 3'd1; vd = '0;
        for (int s = 0; s < 2; s++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== ((s == 0) ? 10'h100 : 10'h3FF)) begin
                    n_bad++; $display("FAIL di2vid_p1 s%0d ch%0d got %h", s, c, tmds1[10*c +: 10]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== ((s == 0) ? terc_tab[15] : 10'h100)) begin
                    n_bad++; $display("FAIL di2vid_p2 s%0d ch%0d got %h", s, c, tmds2[10*c +: 10]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 3'd1; vd = '0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < NCH; c++) begin
            n_cmp++;
            if (tmds1[10*c +: 10] !== 10'h354) begin
                n_bad++; $display("FAIL arst_p1 ch%0d got %h want 354", c, tmds1[10*c +: 10]);
            end
            n_cmp++;
            if (tmds2[10*c +: 10] !== 10'h354) begin
                n_bad++; $display("FAIL arst_p2 ch%0d got %h want 354", c, tmds2[10*c +: 10]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== ((s == 0) ? 10'h100 : 10'h3FF)) begin
                    n_bad++; $display("FAIL postrst_p1 s%0d ch%0d got %h", s, c, tmds1[10*c +: 10]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== ((s == 0) ? 10'h354 : 10'h100)) begin
                    n_bad++; $display("FAIL postrst_p2 s%0d ch%0d got %h", s, c, tmds2[10*c +: 10]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            mode = ($urandom_range(0, 3) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
            vd   = 24'($urandom);
            cd   = 6'($urandom);
            aux  = 12'($urandom);
            ce   = ($urandom_range(0, 7) != 0);
            step();
            for (int c = 0; c < NCH; c++) begin
                n_cmp++;
                if (tmds1[10*c +: 10] !== exp1[c]) begin
                    n_bad++; $display("FAIL rand_p1 n%0d ch%0d got %h want %h", n, c, tmds1[10*c +: 10], exp1[c]);
                end
                n_cmp++;
                if (tmds2[10*c +: 10] !== exp2[c]) begin
                    n_bad++; $display("FAIL rand_p2 n%0d ch%0d got %h want %h", n, c, tmds2[10*c +: 10], exp2[c]);
                end
            end
        end
        ce = 1'b1;
    endtask

    initial begin
        test_reset();
        test_video_zero();
        test_ce_hold();
        test_guard_bands();
        test_data_island();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
